// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// Optional statistics counters are enabled with SRAM_ARB_STATS_EN.
package sram_arb_pkg;

    localparam int AHB_DWIDTH = 32;
    localparam int BE_WIDTH   = 4;
    localparam int STAT_WIDTH = 16;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    typedef enum logic [1:0] {
        ST_RR    = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic    valid;
        req_id_e id;
    } rsp_tag_t;

    function automatic req_id_e other_req(input req_id_e id);
        return (id == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/sram_arb_rsp_pipe.sv
// Read-response tag delay line; steers SRAM read data to the requester
// that issued the read, holding each requester's last returned word.
module sram_arb_rsp_pipe
    import sram_arb_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  rsp_tag_t              issue_i,
    input  logic [AHB_DWIDTH-1:0] mem_rdata_i,
    output logic                  rspa_valid_o,
    output logic [AHB_DWIDTH-1:0] rspa_rdata_o,
    output logic                  rspb_valid_o,
    output logic [AHB_DWIDTH-1:0] rspb_rdata_o
);

    localparam int DEPTH = RD_LATENCY + 1;

    rsp_tag_t              tag_q [DEPTH];
    rsp_tag_t              tag_out;
    logic [AHB_DWIDTH-1:0] hold_a_q;
    logic [AHB_DWIDTH-1:0] hold_b_q;
    logic                  hit_a;
    logic                  hit_b;

    assign tag_out = tag_q[DEPTH-1];
    assign hit_a   = tag_out.valid && (tag_out.id == REQ_A);
    assign hit_b   = tag_out.valid && (tag_out.id == REQ_B);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
            hold_a_q <= '0;
            hold_b_q <= '0;
        end else begin
            tag_q[0] <= issue_i;
            for (int i = 1; i < DEPTH; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            if (hit_a) begin
                hold_a_q <= mem_rdata_i;
            end
            if (hit_b) begin
                hold_b_q <= mem_rdata_i;
            end
        end
    end

    // Data is forwarded in the cycle the SRAM presents it, then held.
    assign rspa_valid_o = hit_a;
    assign rspb_valid_o = hit_b;
    assign rspa_rdata_o = hit_a ? mem_rdata_i : hold_a_q;
    assign rspb_rdata_o = hit_b ? mem_rdata_i : hold_b_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-requester SRAM port arbiter: round-robin with lock ownership.
// Define SRAM_ARB_STATS_EN to add conflict / lock-stall counters.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int MEM_AWIDTH = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  rqa_valid,
    input  logic                  rqa_write,
    input  logic [MEM_AWIDTH-1:0] rqa_addr,
    input  logic [BE_WIDTH-1:0]   rqa_byteen,
    input  logic [AHB_DWIDTH-1:0] rqa_wdata,
    input  logic                  rqa_lock,
    output logic                  rqa_ready,
    input  logic                  rqb_valid,
    input  logic                  rqb_write,
    input  logic [MEM_AWIDTH-1:0] rqb_addr,
    input  logic [BE_WIDTH-1:0]   rqb_byteen,
    input  logic [AHB_DWIDTH-1:0] rqb_wdata,
    input  logic                  rqb_lock,
    output logic                  rqb_ready,
    output logic                  rspa_valid,
    output logic [AHB_DWIDTH-1:0] rspa_rdata,
    output logic                  rspb_valid,
    output logic [AHB_DWIDTH-1:0] rspb_rdata,
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic [MEM_AWIDTH-1:0] mem_addr,
    output logic [BE_WIDTH-1:0]   mem_byteen,
    output logic [AHB_DWIDTH-1:0] mem_wdata,
    input  logic [AHB_DWIDTH-1:0] mem_rdata
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] stat_conflict,
    output logic [STAT_WIDTH-1:0] stat_lock_stall
`endif
);

    arb_state_e            state_q;
    arb_state_e            state_d;
    req_id_e               last_q;
    req_id_e               last_d;

    logic                  gnt_a;
    logic                  gnt_b;
    logic                  xfer;
    req_id_e               sel_id;
    logic                  sel_write;
    logic                  sel_lock;
    logic [MEM_AWIDTH-1:0] sel_addr;
    logic [BE_WIDTH-1:0]   sel_byteen;
    logic [AHB_DWIDTH-1:0] sel_wdata;
    rsp_tag_t              issue;

    logic                  ren_q;
    logic                  wen_q;
    logic [MEM_AWIDTH-1:0] addr_q;
    logic [BE_WIDTH-1:0]   byteen_q;
    logic [AHB_DWIDTH-1:0] wdata_q;

    // Grants are suppressed during reset so nothing transfers then.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!HRESET) begin
            unique case (state_q)
                ST_OWN_A: gnt_a = rqa_valid;
                ST_OWN_B: gnt_b = rqb_valid;
                default: begin
                    if (rqa_valid && rqb_valid) begin
                        gnt_a = (other_req(last_q) == REQ_A);
                        gnt_b = (other_req(last_q) == REQ_B);
                    end else begin
                        gnt_a = rqa_valid;
                        gnt_b = rqb_valid;
                    end
                end
            endcase
        end
    end

    assign rqa_ready = gnt_a;
    assign rqb_ready = gnt_b;
    assign xfer      = gnt_a || gnt_b;

    assign sel_id     = gnt_b ? REQ_B : REQ_A;
    assign sel_write  = gnt_b ? rqb_write : rqa_write;
    assign sel_lock   = gnt_b ? rqb_lock : rqa_lock;
    assign sel_addr   = gnt_b ? rqb_addr : rqa_addr;
    assign sel_byteen = gnt_b ? rqb_byteen : rqa_byteen;
    assign sel_wdata  = gnt_b ? rqb_wdata : rqa_wdata;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        if (xfer) begin
            last_d = sel_id;
        end
        if (xfer && sel_lock) begin
            state_d = (sel_id == REQ_A) ? ST_OWN_A : ST_OWN_B;
        end else begin
            unique case (state_q)
                ST_OWN_A: begin
                    if (gnt_a || !rqa_valid) begin
                        state_d = ST_RR;
                    end
                end
                ST_OWN_B: begin
                    if (gnt_b || !rqb_valid) begin
                        state_d = ST_RR;
                    end
                end
                default: state_d = ST_RR;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= ST_RR;
            last_q   <= REQ_B;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            byteen_q <= '0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            ren_q   <= xfer && !sel_write;
            wen_q   <= xfer && sel_write;
            if (xfer) begin
                addr_q   <= sel_addr;
                byteen_q <= sel_byteen;
                wdata_q  <= sel_wdata;
            end
        end
    end

    assign mem_ren    = ren_q;
    assign mem_wen    = wen_q;
    assign mem_addr   = addr_q;
    assign mem_byteen = byteen_q;
    assign mem_wdata  = wdata_q;

    assign issue.valid = xfer && !sel_write;
    assign issue.id    = sel_id;

    sram_arb_rsp_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rsp_pipe (
        .clk_i        (HCLK),
        .rst_i        (HRESET),
        .issue_i      (issue),
        .mem_rdata_i  (mem_rdata),
        .rspa_valid_o (rspa_valid),
        .rspa_rdata_o (rspa_rdata),
        .rspb_valid_o (rspb_valid),
        .rspb_rdata_o (rspb_rdata)
    );

`ifdef SRAM_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] conflict_q;
    logic [STAT_WIDTH-1:0] lock_stall_q;
    logic                  both_valid;
    logic                  lock_blocked;

    assign both_valid   = rqa_valid && rqb_valid;
    assign lock_blocked = ((state_q == ST_OWN_A) && rqb_valid)
                       || ((state_q == ST_OWN_B) && rqa_valid);

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            conflict_q   <= '0;
            lock_stall_q <= '0;
        end else begin
            if (both_valid && (conflict_q != '1)) begin
                conflict_q <= conflict_q + 1'b1;
            end
            if (lock_blocked && (lock_stall_q != '1)) begin
                lock_stall_q <= lock_stall_q + 1'b1;
            end
        end
    end

    assign stat_conflict   = conflict_q;
    assign stat_lock_stall = lock_stall_q;
`endif

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter MEM_AWIDTH, default 16, SRAM word-address width.
REQ-002 Parameter RD_LATENCY, default 1, SRAM read latency in HCLK cycles after mem_ren; legal values are 1 and 2.
REQ-003 Ports:
- HCLK, in, 1: the single clock.
- HRESET, in, 1: reset, synchronous and active-high.
- rqa_valid / rqb_valid, in, 1: requester A/B command valid.
- rqa_write / rqb_write, in, 1: 1 = write, 0 = read.
- rqa_addr / rqb_addr, in, MEM_AWIDTH: word address.
- rqa_byteen / rqb_byteen, in, 4: byte enables.
- rqa_wdata / rqb_wdata, in, 32: write data.
- rqa_lock / rqb_lock, in, 1: hold ownership after this command.
- rqa_ready / rqb_ready, out, 1: command accepted this cycle.
- rspa_valid / rspb_valid, out, 1: read data valid.
- rspa_rdata / rspb_rdata, out, 32: read data.
- mem_ren / mem_wen, out, 1: SRAM strobes.
- mem_addr, out, MEM_AWIDTH: SRAM address.
- mem_byteen, out, 4: SRAM byte enables.
- mem_wdata, out, 32: SRAM write data.
- mem_rdata, in, 32: SRAM read data.

Function
REQ-004 A command on requester X transfers when rqX_valid and rqX_ready are both 1 in the same cycle; at most one transfer occurs per cycle.
REQ-005 rqX_ready is combinational from the valids and the arbiter state; it is never 1 for both requesters in one cycle; it is 0 whenever rqX_valid is 0.
REQ-006 Arbitration FSM states are RR, OWN_A and OWN_B.
- RR with a single valid requester: that requester is granted.
- RR with both valid: the requester not granted last is granted.
REQ-007 In OWN_X, only X is granted; the other requester waits.
REQ-008 Lock transitions:
- Any state to OWN_X: when X transfers with rqX_lock=1.
- OWN_X to RR: when X transfers with rqX_lock=0, or when rqX_valid=0 in OWN_X.
REQ-009 The last-grant register updates on every transfer.
REQ-010 A transfer in cycle N drives mem_ren or mem_wen, mem_addr, mem_byteen and mem_wdata from registers in cycle N+1 only; with no transfer in cycle N, mem_ren=mem_wen=0 in N+1.
REQ-011 A read transferred in cycle N returns mem_rdata on rspX_rdata with rspX_valid=1 in cycle N+1+RD_LATENCY, for exactly one cycle, to the issuing requester only.
REQ-012 Writes produce no response.
REQ-013 Responses return in issue order; back-to-back reads from alternating requesters sustain one transfer per cycle with no bubbles.
REQ-014 rspX_rdata holds its last value when rspX_valid=0.

Reset
REQ-015 While HRESET=1 at a rising edge:
- FSM goes to RR; last grant = B, so A wins the first tie.
- mem_ren, mem_wen, mem_addr, mem_byteen, mem_wdata, rspa/rspb_valid and rspa/rspb_rdata all go to 0.
REQ-016 Reads in flight when reset asserts are discarded; no rspX_valid follows reset release.
REQ-017 rqX_ready is 0 during any cycle with HRESET=1.

Configuration
REQ-018 With macro SRAM_ARB_STATS_EN defined:
- Output ports stat_conflict (16 bits) and stat_lock_stall (16 bits) exist.
- stat_conflict increments in each cycle where both valids are 1.
- stat_lock_stall increments in each cycle where a requester is valid but blocked by the other's OWN state.
- Both counters saturate at 16'hFFFF and reset to 0.
REQ-019 Without SRAM_ARB_STATS_EN, those ports and counters do not exist, and all other behaviour is identical.

Structure
REQ-020 Shared package sram_arb_pkg holds:
- AHB_DWIDTH=32 and byte-enable width 4.
- The requester-ID type (REQ_A, REQ_B).
- The FSM state type.
- The response-tag type (valid bit plus requester ID).
REQ-021 One sub-module, sram_arb_rsp_pipe, is an RD_LATENCY+1 deep tag delay line that routes mem_rdata to the issuing requester.

Verification
REQ-022 Reset: hold HRESET=1 for 3 cycles with both valids=1 -> rqa/rqb_ready=0 and all mem_* and rsp* outputs=0; after release, the first grant is A.
REQ-023 Tie: both valids held 1, reads at addresses 0x10 (A) and 0x20 (B) -> grants alternate A,B,A,B, mem_addr sequence 0x10,0x20,0x10,0x20, rdata routed to the matching requester at N+1+RD_LATENCY.
REQ-024 Lock: A issues 3 writes with lock=1,1,0 while B is valid -> B stalled 3 cycles, B granted in the 4th; with stats enabled, stat_lock_stall=2.
REQ-025 Latency: RD_LATENCY=2, single A read at 0x1234 in cycle 5 -> mem_ren=1 in cycle 6, rspa_valid=1 in cycle 8 with mem_rdata value, rspb_valid stays 0.
REQ-026 Reset mid-flight: B read accepted, then HRESET pulsed in the next cycle -> no rspb_valid afterwards.
REQ-027 Saturation: SRAM_ARB_STATS_EN defined, 70000 conflict cycles -> stat_conflict=16'hFFFF.
